// File: rtl/loop_sequencer_if.sv
// Control/status bundle between an instruction decoder and the loop sequencer.
// The decoder drives the per-instruction controls and observes the fetch address and loop-stack status.
interface loop_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             jump;
    logic [15:0]      jump_a;
    logic             loop_we;
    logic [15:0]      loop_end;
    logic [CNT_W-1:0] loop_count;
    logic [15:0]      pc;
    logic             loop_active;
    logic [2:0]       loop_depth;
    logic             loop_ovf;

    modport master (
        output stall,
        output jump,
        output jump_a,
        output loop_we,
        output loop_end,
        output loop_count,
        input  pc,
        input  loop_active,
        input  loop_depth,
        input  loop_ovf
    );

    modport slave (
        input  stall,
        input  jump,
        input  jump_a,
        input  loop_we,
        input  loop_end,
        input  loop_count,
        output pc,
        output loop_active,
        output loop_depth,
        output loop_ovf
    );
endinterface

// File: rtl/loop_sequencer.sv
// Zero-overhead hardware loop sequencer: registered fetch address with a small loop stack
// (start/end/count per entry); the top two entries are checked against pc every cycle.
module loop_sequencer #(
    parameter int LOOP_DEPTH = 4,   // legal range 1..7 (depth is reported on 3 bits)
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    loop_sequencer_if.slave bus
);
    localparam logic [2:0]       DEPTH_MAX = 3'(LOOP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [15:0] addr_inc(input logic [15:0] a);
        return a + 16'd1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return c - CNT_ONE;
    endfunction

    logic [15:0]      pc_q;
    logic [15:0]      pc_n;
    logic [2:0]       depth_q;
    logic [2:0]       depth_n;
    logic             ovf_q;
    logic             ovf_n;

    logic [15:0]      start_q [LOOP_DEPTH];
    logic [15:0]      end_q   [LOOP_DEPTH];
    logic [CNT_W-1:0] cnt_q   [LOOP_DEPTH];

    logic [2:0]       top_idx;
    logic [2:0]       next_idx;
    logic             has_top;
    logic             has_next;
    logic [15:0]      top_start;
    logic [15:0]      top_end;
    logic [CNT_W-1:0] top_cnt;
    logic [15:0]      next_start;
    logic [15:0]      next_end;
    logic [CNT_W-1:0] next_cnt;

    logic             push;
    logic             dec_top;
    logic             dec_next;

    assign top_idx  = depth_q - 3'd1;
    assign next_idx = depth_q - 3'd2;
    assign has_top  = (depth_q != 3'd0);
    assign has_next = (depth_q >= 3'd2);

    // Index-compare muxing keeps every array access in range, even when the stack is empty.
    always_comb begin
        top_start  = '0;
        top_end    = '0;
        top_cnt    = '0;
        next_start = '0;
        next_end   = '0;
        next_cnt   = '0;
        for (int i = 0; i < LOOP_DEPTH; i++) begin
            if (3'(i) == top_idx) begin
                top_start = start_q[i];
                top_end   = end_q[i];
                top_cnt   = cnt_q[i];
            end
            if (3'(i) == next_idx) begin
                next_start = start_q[i];
                next_end   = end_q[i];
                next_cnt   = cnt_q[i];
            end
        end
    end

    // Next-pc selection: jump > loop setup > loop-end match > sequential.
    always_comb begin
        pc_n     = addr_inc(pc_q);
        depth_n  = depth_q;
        ovf_n    = ovf_q;
        push     = 1'b0;
        dec_top  = 1'b0;
        dec_next = 1'b0;
        if (bus.stall) begin
            pc_n = pc_q;
        end else if (bus.jump) begin
            pc_n = bus.jump_a;
        end else if (bus.loop_we) begin
            if (bus.loop_count == '0) begin
                pc_n = addr_inc(bus.loop_end);
            end else if (depth_q >= DEPTH_MAX) begin
                ovf_n = 1'b1;
            end else begin
                push    = 1'b1;
                depth_n = depth_q + 3'd1;
            end
        end else if (has_top && (pc_q == top_end)) begin
            if (top_cnt > CNT_ONE) begin
                dec_top = 1'b1;
                pc_n    = top_start;
            end else begin
                depth_n = depth_q - 3'd1;
                // Loops sharing an end address resolve in the same cycle.
                if (has_next && (next_end == pc_q)) begin
                    if (next_cnt > CNT_ONE) begin
                        dec_next = 1'b1;
                        pc_n     = next_start;
                    end else begin
                        depth_n = depth_q - 3'd2;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else if (!bus.stall) begin
            pc_q    <= pc_n;
            depth_q <= depth_n;
            ovf_q   <= ovf_n;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                if (push && (3'(i) == depth_q)) begin
                    start_q[i] <= addr_inc(pc_q);
                    end_q[i]   <= bus.loop_end;
                    cnt_q[i]   <= bus.loop_count;
                end
                if (dec_top && (3'(i) == top_idx)) begin
                    cnt_q[i] <= cnt_dec(top_cnt);
                end
                if (dec_next && (3'(i) == next_idx)) begin
                    cnt_q[i] <= cnt_dec(next_cnt);
                end
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.loop_depth  = depth_q;
    assign bus.loop_active = has_top;
    assign bus.loop_ovf    = ovf_q;
endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: each stimulus cycle queues the expected post-edge state,
// and an independent monitor compares it against the DUT after every rising edge.
module tb_loop_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    loop_sequencer_if #(.CNT_W(16)) bus ();

    loop_sequencer #(.LOOP_DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  depth;
        logic        ovf;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    task automatic chk(input string name, input int st, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, st, act, want);
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic j, input logic [15:0] ja,
                       input logic we, input logic [15:0] le, input logic [15:0] lc,
                       input logic [15:0] epc, input logic [2:0] ed, input logic eo);
        exp_t e;
        @(negedge clk);
        reset_n        = r;
        bus.stall      = st;
        bus.jump       = j;
        bus.jump_a     = ja;
        bus.loop_we    = we;
        bus.loop_end   = le;
        bus.loop_count = lc;
        step++;
        e.pc    = epc;
        e.depth = ed;
        e.ovf   = eo;
        e.step  = step;
        exp_q.push_back(e);
    endtask

    task automatic nop(input logic [15:0] epc, input logic [2:0] ed, input logic eo);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, epc, ed, eo);
    endtask

    task automatic push_l(input logic [15:0] le, input logic [15:0] lc,
                          input logic [15:0] epc, input logic [2:0] ed, input logic eo);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, le, lc, epc, ed, eo);
    endtask

    task automatic jmp(input logic [15:0] ja, input logic [15:0] epc, input logic [2:0] ed, input logic eo);
        cyc(1'b1, 1'b0, 1'b1, ja, 1'b0, 16'h0, 16'h0, epc, ed, eo);
    endtask

    task automatic stl(input logic j, input logic we, input logic [15:0] epc, input logic [2:0] ed);
        cyc(1'b1, 1'b1, j, 16'h0077, we, 16'h0077, 16'd3, epc, ed, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", e.step, 32'(bus.pc), 32'(e.pc));
                chk("loop_depth", e.step, 32'(bus.loop_depth), 32'(e.depth));
                chk("loop_active", e.step, 32'(bus.loop_active), 32'(e.depth != 3'd0));
                chk("loop_ovf", e.step, 32'(bus.loop_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog step=%0d got=timeout want=finish", step);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.stall      = 1'b0;
        bus.jump       = 1'b0;
        bus.jump_a     = 16'h0;
        bus.loop_we    = 1'b0;
        bus.loop_end   = 16'h0;
        bus.loop_count = 16'h0;

        // held in reset with active controls: state stays cleared
        cyc(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0009, 16'h2, 16'h0, 3'd0, 1'b0);

        // release: sequential fetch
        for (int v = 1; v <= 5; v++) nop(16'(v), 3'd0, 1'b0);

        // single loop at pc=2, end=4, count=3
        jmp(16'h0002, 16'h0002, 3'd0, 1'b0);
        push_l(16'h0004, 16'd3, 16'h0003, 3'd1, 1'b0);
        nop(16'h0004, 3'd1, 1'b0);
        nop(16'h0003, 3'd1, 1'b0);
        nop(16'h0004, 3'd1, 1'b0);
        nop(16'h0003, 3'd1, 1'b0);
        nop(16'h0004, 3'd1, 1'b0);
        nop(16'h0005, 3'd0, 1'b0);
        nop(16'h0006, 3'd0, 1'b0);

        // zero-count loop skips the body
        jmp(16'h000A, 16'h000A, 3'd0, 1'b0);
        push_l(16'h0014, 16'd0, 16'h0015, 3'd0, 1'b0);
        nop(16'h0016, 3'd0, 1'b0);

        // nested loops sharing end=5; the setup at pc=1 is re-issued whenever it is fetched
        jmp(16'h0000, 16'h0000, 3'd0, 1'b0);
        push_l(16'h0005, 16'd2, 16'h0001, 3'd1, 1'b0);
        push_l(16'h0005, 16'd2, 16'h0002, 3'd2, 1'b0);
        for (int v = 3; v <= 5; v++) nop(16'(v), 3'd2, 1'b0);
        nop(16'h0002, 3'd2, 1'b0);
        for (int v = 3; v <= 5; v++) nop(16'(v), 3'd2, 1'b0);
        nop(16'h0001, 3'd1, 1'b0);
        push_l(16'h0005, 16'd2, 16'h0002, 3'd2, 1'b0);
        for (int v = 3; v <= 5; v++) nop(16'(v), 3'd2, 1'b0);
        nop(16'h0002, 3'd2, 1'b0);
        for (int v = 3; v <= 5; v++) nop(16'(v), 3'd2, 1'b0);
        nop(16'h0006, 3'd0, 1'b0);

        // stall at the loop end, then jump out while the loop is live
        jmp(16'h0030, 16'h0030, 3'd0, 1'b0);
        push_l(16'h0032, 16'd2, 16'h0031, 3'd1, 1'b0);
        nop(16'h0032, 3'd1, 1'b0);
        stl(1'b0, 1'b0, 16'h0032, 3'd1);
        stl(1'b1, 1'b0, 16'h0032, 3'd1);
        stl(1'b0, 1'b1, 16'h0032, 3'd1);
        nop(16'h0031, 3'd1, 1'b0);
        nop(16'h0032, 3'd1, 1'b0);
        jmp(16'h0100, 16'h0100, 3'd1, 1'b0);
        nop(16'h0101, 3'd1, 1'b0);
        jmp(16'h0032, 16'h0032, 3'd1, 1'b0);
        nop(16'h0033, 3'd0, 1'b0);

        // setup on a loop-end address wins over the end match; distinct ends do not cascade
        jmp(16'h0040, 16'h0040, 3'd0, 1'b0);
        push_l(16'h0042, 16'd2, 16'h0041, 3'd1, 1'b0);
        nop(16'h0042, 3'd1, 1'b0);
        push_l(16'h0050, 16'd1, 16'h0043, 3'd2, 1'b0);
        jmp(16'h0050, 16'h0050, 3'd2, 1'b0);
        nop(16'h0051, 3'd1, 1'b0);
        jmp(16'h0042, 16'h0042, 3'd1, 1'b0);
        nop(16'h0041, 3'd1, 1'b0);
        nop(16'h0042, 3'd1, 1'b0);
        nop(16'h0043, 3'd0, 1'b0);

        // address wrap inside a loop body
        jmp(16'hFFFE, 16'hFFFE, 3'd0, 1'b0);
        push_l(16'h0001, 16'd2, 16'hFFFF, 3'd1, 1'b0);
        nop(16'h0000, 3'd1, 1'b0);
        nop(16'h0001, 3'd1, 1'b0);
        nop(16'hFFFF, 3'd1, 1'b0);
        nop(16'h0000, 3'd1, 1'b0);
        nop(16'h0001, 3'd1, 1'b0);
        nop(16'h0002, 3'd0, 1'b0);

        // overflow: fifth push is dropped and the flag sticks
        jmp(16'h0200, 16'h0200, 3'd0, 1'b0);
        push_l(16'h0300, 16'd1, 16'h0201, 3'd1, 1'b0);
        push_l(16'h0300, 16'd1, 16'h0202, 3'd2, 1'b0);
        push_l(16'h0300, 16'd1, 16'h0203, 3'd3, 1'b0);
        push_l(16'h0300, 16'd1, 16'h0204, 3'd4, 1'b0);
        push_l(16'h0300, 16'd1, 16'h0205, 3'd4, 1'b1);
        nop(16'h0206, 3'd4, 1'b1);
        jmp(16'h0300, 16'h0300, 3'd4, 1'b1);
        nop(16'h0301, 3'd2, 1'b1);
        jmp(16'h0300, 16'h0300, 3'd2, 1'b1);
        nop(16'h0301, 3'd0, 1'b1);
        push_l(16'h0310, 16'd5, 16'h0302, 3'd1, 1'b1);
        nop(16'h0303, 3'd1, 1'b1);

        // asynchronous reset mid-loop, checked before any clock edge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_pc", step, 32'(bus.pc), 32'h0);
        chk("async_depth", step, 32'(bus.loop_depth), 32'h0);
        chk("async_active", step, 32'(bus.loop_active), 32'h0);
        chk("async_ovf", step, 32'(bus.loop_ovf), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        nop(16'h0001, 3'd0, 1'b0);
        nop(16'h0002, 3'd0, 1'b0);
        jmp(16'h0310, 16'h0310, 3'd0, 1'b0);
        nop(16'h0311, 3'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", step, 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
